// File: rtl/slt_arb_pkg.sv
// Shared types and the round-robin search used by the slt_arbiter block.
package slt_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMP  = 2'd1,
      RESP = 2'd2
   } arb_state_t;

   // Upper bound on requester count; callers pad their valid vector to this.
   localparam int unsigned MAX_R = 64;

   // First set bit of valid at or above ptr, wrapping modulo r.
   function automatic void next_grant(
      input  logic [MAX_R-1:0] valid,
      input  int unsigned      ptr,
      input  int unsigned      r,
      output int unsigned      idx,
      output logic             found
   );
      int unsigned j;
      idx   = 0;
      found = 1'b0;
      for (int unsigned k = 0; k < MAX_R; k++) begin
         if (k < r) begin
            j = ptr + k;
            if (j >= r) j = j - r;
            if (!found && valid[j]) begin
               idx   = j;
               found = 1'b1;
            end
         end
      end
   endfunction

endpackage

// File: rtl/adder_n.sv
// Plain N-bit adder with carry-in; the shared compare datapath is built on it.
module adder_n #(
   parameter int N = 32
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         c_in,
   output logic [N-1:0] sum
);

   assign sum = a + b + N'(c_in);

endmodule

// File: rtl/slt_core.sv
// Combinational signed less-than: a - b computed as a + ~b + 1 on one adder.
module slt_core #(
   parameter int N = 32
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         lt,
   output logic         over
);

   logic [N-1:0] diff;
   logic [N-1:0] b_inv;

   assign b_inv = ~b;

   adder_n #(.N(N)) u_add (
      .a    (a),
      .b    (b_inv),
      .c_in (1'b1),
      .sum  (diff)
   );

   // Overflow only when operand signs differ and the result sign leaves a's.
   assign over = (a[N-1] != b[N-1]) & (diff[N-1] != a[N-1]);
   assign lt   = diff[N-1] ^ over;

endmodule

// File: rtl/slt_arbiter.sv
// Round-robin arbiter sharing one signed compare among R requesters.
// Handshake: a transfer happens on an edge where valid and ready are both 1.
module slt_arbiter
   import slt_arb_pkg::*;
#(
   parameter int N    = 32,
   parameter int R    = 4,
   parameter int ID_W = $clog2(R)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [R-1:0]    req_valid,
   output logic [R-1:0]    req_ready,
   input  logic [R*N-1:0]  req_a,
   input  logic [R*N-1:0]  req_b,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [ID_W-1:0] resp_id,
   output logic            resp_lt,
   output logic            resp_over
);

   arb_state_t      state;
   arb_state_t      state_nxt;
   logic [ID_W-1:0] ptr;
   logic [ID_W-1:0] grant;
   logic [N-1:0]    op_a;
   logic [N-1:0]    op_b;

   logic [MAX_R-1:0] valid_pad;
   int unsigned      pick_idx;
   logic             pick_found;
   logic [ID_W-1:0]  pick;
   logic             core_lt;
   logic             core_over;

   slt_core #(.N(N)) u_core (
      .a    (op_a),
      .b    (op_b),
      .lt   (core_lt),
      .over (core_over)
   );

   always_comb begin
      valid_pad          = '0;
      valid_pad[R-1:0]   = req_valid;
      pick_idx           = 0;
      pick_found         = 1'b0;
      next_grant(valid_pad, 32'(ptr), R, pick_idx, pick_found);
      pick               = ID_W'(pick_idx);
   end

   always_comb begin
      state_nxt = state;
      req_ready = '0;
      case (state)
         IDLE: begin
            if (pick_found) begin
               req_ready[pick] = 1'b1;
               state_nxt       = CMP;
            end
         end
         CMP:     state_nxt = RESP;
         RESP:    if (resp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      // Grants must vanish the instant reset asserts, not at the next edge.
      if (!rst_n) req_ready = '0;
   end

   assign resp_valid = (state == RESP);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ptr       <= '0;
         grant     <= '0;
         op_a      <= '0;
         op_b      <= '0;
         resp_id   <= '0;
         resp_lt   <= 1'b0;
         resp_over <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (pick_found) begin
                  grant <= pick;
                  op_a  <= req_a[int'(pick)*N +: N];
                  op_b  <= req_b[int'(pick)*N +: N];
               end
            end
            CMP: begin
               resp_id   <= grant;
               resp_lt   <= core_lt;
               resp_over <= core_over;
            end
            RESP: begin
               // The requester just served becomes lowest priority next time.
               if (resp_ready)
                  ptr <= (grant == ID_W'(R-1)) ? '0 : grant + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_slt_arbiter.sv
// Bench for slt_arbiter: directed corner cases plus randomized traffic
// checked every cycle against a transaction-level model.
module tb_slt_arbiter;

   localparam int N    = 32;
   localparam int R    = 4;
   localparam int ID_W = 2;

   logic            clk   = 1'b0;
   logic            rst_n = 1'b1;
   logic [R-1:0]    req_valid;
   logic [R-1:0]    req_ready;
   logic [R*N-1:0]  req_a;
   logic [R*N-1:0]  req_b;
   logic            resp_valid;
   logic            resp_ready;
   logic [ID_W-1:0] resp_id;
   logic            resp_lt;
   logic            resp_over;

   logic [N-1:0] op_a[R];
   logic [N-1:0] op_b[R];

   int total = 0;
   int bad   = 0;

   slt_arbiter #(.N(N), .R(R), .ID_W(ID_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_id    (resp_id),
      .resp_lt    (resp_lt),
      .resp_over  (resp_over)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < R; i++) begin
         req_a[i*N +: N] = op_a[i];
         req_b[i*N +: N] = op_b[i];
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Signed compare from the arithmetic definition, using wide integers.
   function automatic void ref_cmp(input logic [N-1:0] a, input logic [N-1:0] b,
                                   output logic lt, output logic ov);
      longint sa, sb, d, lim;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      d   = sa - sb;
      lim = longint'(1) <<< (N-1);
      lt  = (sa < sb);
      ov  = (d > lim - 1) || (d < -lim);
   endfunction

   function automatic logic [N-1:0] rnd_op();
      case ($urandom_range(0, 5))
         0:       return '0;
         1:       return 32'h8000_0000;
         2:       return 32'h7FFF_FFFF;
         3:       return '1;
         default: return $urandom();
      endcase
   endfunction

   // ---------------- scoreboard / model ----------------
   int   cyc       = 0;
   bit   m_busy    = 1'b0;
   int   m_ptr     = 0;
   int   m_resp_at = 0;
   int   m_id      = 0;
   logic m_lt      = 1'b0;
   logic m_ov      = 1'b0;
   logic [ID_W+1:0] exp_q[$];

   always @(negedge clk) begin
      logic [R-1:0]    er;
      logic            erv;
      logic [ID_W+1:0] e;
      int              pick;
      if (!rst_n) begin
         chk("rst_req_ready", req_ready, 0);
         chk("rst_resp_valid", resp_valid, 0);
         chk("rst_resp_id", resp_id, 0);
         chk("rst_resp_lt", resp_lt, 0);
         chk("rst_resp_over", resp_over, 0);
         m_busy = 1'b0;
         m_ptr  = 0;
         exp_q.delete();
      end else begin
         cyc++;
         er   = '0;
         pick = -1;
         if (!m_busy)
            for (int k = 0; k < R; k++)
               if (pick < 0 && req_valid[(m_ptr + k) % R]) pick = (m_ptr + k) % R;
         if (pick >= 0) er[pick] = 1'b1;
         chk("req_ready", req_ready, er);
         erv = m_busy && (cyc >= m_resp_at);
         chk("resp_valid", resp_valid, erv);
         if (erv && resp_valid && exp_q.size() > 0) begin
            e = exp_q[0];
            chk("resp_id", resp_id, e[ID_W+1:2]);
            chk("resp_lt", resp_lt, e[1]);
            chk("resp_over", resp_over, e[0]);
         end
         if (pick >= 0) begin
            m_busy    = 1'b1;
            m_resp_at = cyc + 2;
            m_id      = pick;
            ref_cmp(op_a[pick], op_b[pick], m_lt, m_ov);
            exp_q.push_back({ID_W'(pick), m_lt, m_ov});
         end else if (erv && resp_ready) begin
            m_busy = 1'b0;
            m_ptr  = (m_id + 1) % R;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic run_one(input int id, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic elt, input logic eov);
      @(posedge clk); #1;
      op_a[id]   = a;
      op_b[id]   = b;
      req_valid  = R'(1) << id;
      resp_ready = 1'b1;
      @(negedge clk);
      chk("one_grant", req_ready, R'(1) << id);
      @(posedge clk); #1;
      req_valid = '0;
      @(negedge clk);
      chk("one_cmp_valid", resp_valid, 0);
      chk("one_cmp_ready", req_ready, 0);
      @(negedge clk);
      chk("one_resp_valid", resp_valid, 1);
      chk("one_resp_id", resp_id, id);
      chk("one_resp_lt", resp_lt, elt);
      chk("one_resp_over", resp_over, eov);
      @(posedge clk); #1;
   endtask

   task automatic drain(input int n);
      req_valid  = '0;
      resp_ready = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // ---------------- stimulus ----------------
   int           gid[5];
   int           gcy[5];
   int           ng;
   int           exp_ids[5] = '{0, 1, 2, 3, 0};
   logic [R-1:0] rdy;
   logic [ID_W-1:0] snap_id;
   logic         snap_lt, snap_ov;
   logic         plt, pov;

   initial begin
      req_valid  = '0;
      resp_ready = 1'b0;
      for (int i = 0; i < R; i++) begin
         op_a[i] = '0;
         op_b[i] = '0;
      end

      // model pins
      ref_cmp(32'h8000_0000, 32'd1, plt, pov);
      chk("pin_min_lt", plt, 1);
      chk("pin_min_ov", pov, 1);
      ref_cmp(32'h7FFF_FFFF, 32'hFFFF_FFFF, plt, pov);
      chk("pin_max_lt", plt, 0);
      chk("pin_max_ov", pov, 1);
      ref_cmp(32'd5, 32'd3, plt, pov);
      chk("pin_pos_lt", plt, 0);
      chk("pin_pos_ov", pov, 0);

      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("reset_resp_valid", resp_valid, 0);
      chk("reset_req_ready", req_ready, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // single request and signed/overflow corners
      run_one(0, 32'd5, 32'd3, 1'b0, 1'b0);
      run_one(1, 32'h8000_0000, 32'd1, 1'b1, 1'b1);
      run_one(1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
      run_one(1, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 1'b0, 1'b0);
      drain(2);

      // asynchronous reset while the compare is in flight
      op_a[3]   = 32'd1;
      op_b[3]   = 32'd2;
      req_valid = 4'b1000;
      @(negedge clk);
      chk("mid_grant", req_ready, 4'b1000);
      @(posedge clk); #1;
      req_valid = '0;
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_req_ready", req_ready, 0);
      chk("mid_rst_resp_valid", resp_valid, 0);
      chk("mid_rst_resp_id", resp_id, 0);
      chk("mid_rst_resp_lt", resp_lt, 0);
      chk("mid_rst_resp_over", resp_over, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("no_stale_resp", resp_valid, 0);
      end

      // round-robin fairness, all requesters held valid
      @(posedge clk); #1;
      for (int i = 0; i < R; i++) begin
         op_a[i] = $urandom();
         op_b[i] = $urandom();
      end
      req_valid  = '1;
      resp_ready = 1'b1;
      ng = 0;
      for (int c = 0; c < 30 && ng < 5; c++) begin
         @(negedge clk);
         if (req_ready != 0) begin
            chk("rr_onehot", $countones(req_ready), 1);
            gid[ng] = $clog2(req_ready);
            gcy[ng] = c;
            ng++;
         end
      end
      chk("rr_grant_count", ng, 5);
      for (int i = 0; i < ng; i++) chk("rr_order", gid[i], exp_ids[i]);
      for (int i = 1; i < ng; i++) chk("rr_spacing", gcy[i] - gcy[i-1], 3);
      @(posedge clk); #1;
      drain(5);

      // backpressure on the response
      resp_ready = 1'b0;
      op_a[2]    = 32'hFFFF_FFF9;
      op_b[2]    = 32'd9;
      req_valid  = 4'b0100;
      @(negedge clk);
      chk("bp_grant", req_ready, 4'b0100);
      @(posedge clk); #1;
      op_a[3]   = 32'd4;
      op_b[3]   = 32'd4;
      req_valid = 4'b1000;
      @(negedge clk);
      chk("bp_cmp_ready", req_ready, 0);
      @(negedge clk);
      chk("bp_valid", resp_valid, 1);
      chk("bp_id", resp_id, 2);
      chk("bp_lt", resp_lt, 1);
      chk("bp_over", resp_over, 0);
      snap_id = resp_id;
      snap_lt = resp_lt;
      snap_ov = resp_over;
      repeat (4) begin
         @(negedge clk);
         chk("bp_hold_valid", resp_valid, 1);
         chk("bp_hold_id", resp_id, snap_id);
         chk("bp_hold_lt", resp_lt, snap_lt);
         chk("bp_hold_over", resp_over, snap_ov);
         chk("bp_hold_ready", req_ready, 0);
      end
      @(posedge clk); #1;
      resp_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_valid", resp_valid, 1);
      chk("bp_release_ready", req_ready, 0);
      @(negedge clk);
      chk("bp_next_grant", req_ready, 4'b1000);
      @(posedge clk); #1;
      drain(5);

      // randomized traffic
      for (int it = 0; it < 1500; it++) begin
         @(negedge clk);
         rdy = req_ready;
         @(posedge clk); #1;
         for (int i = 0; i < R; i++) begin
            if (rdy[i] || !req_valid[i]) begin
               if (rdy[i]) req_valid[i] = 1'b0;
               if ($urandom_range(0, 2) == 0) begin
                  req_valid[i] = 1'b1;
                  op_a[i] = rnd_op();
                  op_b[i] = ($urandom_range(0, 4) == 0) ? op_a[i] : rnd_op();
               end
            end else if ($urandom_range(0, 15) == 0) begin
               req_valid[i] = 1'b0;
            end
         end
         resp_ready = ($urandom_range(0, 3) != 0);
      end
      drain(6);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/slt_arbiter.md
# slt_arbiter

Round-robin scheduler that shares one signed less-than comparator among `R` requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester at a time, runs the pair through the comparator, and returns the result tagged with the requester index. It sits between the ALU-side clients and the single comparator instance, so the adder-based compare hardware is not replicated per client.

## Interface
- `N`, default 32: operand width, two's complement.
- `R`, default 4: number of requesters, at least 2.
- `ID_W`, default `$clog2(R)`: width of the requester index.

Ports:
- `clk`, in, 1: rising-edge clock.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `req_valid`, in, `R`: per-requester request valid.
- `req_ready`, out, `R`: per-requester accept. It is one-hot or zero.
- `req_a`, in, `R*N`: flattened operand A. Slice `i` is `[i*N +: N]`.
- `req_b`, in, `R*N`: flattened operand B, same slicing.
- `resp_valid`, out, 1: a result is available.
- `resp_ready`, in, 1: the consumer accepts the result.
- `resp_id`, out, `ID_W`: index of the requester that produced the result.
- `resp_lt`, out, 1: 1 iff `a < b`, signed, strict.
- `resp_over`, out, 1: signed overflow of the N-bit subtraction `a - b`.

## Operation
State machine with three states: IDLE, CMP and RESP.

**IDLE**
- If any `req_valid` bit is set, grant the first requester found searching from `ptr` upward, wrapping modulo `R`.
- Drive `req_ready[grant]` = 1 combinationally in this cycle.
- On the clock edge, capture `req_a` and `req_b` for the granted slice into operand registers, latch `grant`, and go to CMP.
- If no `req_valid` bit is set, stay in IDLE.

**CMP**
- The registered operands drive the comparator.
- `diff = a + ~b + 1` (N bits). `over = (a[N-1] != b[N-1]) & (diff[N-1] != a[N-1])`. `lt = diff[N-1] ^ over`.
- On the clock edge, register `lt`, `over` and `grant` into the `resp_*` outputs and go to RESP.

**RESP**
- `resp_valid` = 1. All `resp_*` outputs are held stable until `resp_ready` = 1.
- On the handshake edge: `ptr <= (grant + 1) mod R`, go to IDLE.
- No grants are issued while in CMP or RESP; `req_ready` is all zero in those states.

Requester rules:
- A requester must hold `req_valid` and its operands stable until it sees `req_ready`.
- Dropping `req_valid` before it is granted is permitted; that requester simply is not considered.

Reset:
- `rst_n` low forces, immediately: state IDLE, `ptr` 0, `req_ready` 0, `resp_valid` 0, `resp_id` 0, `resp_lt` 0, `resp_over` 0, operand registers 0.
- Reset in CMP or RESP discards the in-flight compare. No response is produced for it.

Boundary cases:
- `a == b` gives `lt` = 0, `over` = 0.
- Most-negative minus positive: `over` = 1 and `lt` = 1.
- `ptr` wraps from `R-1` to 0.
- If a requester whose result is in RESP re-asserts `req_valid`, it is only considered in the next IDLE, and it has the lowest priority there.

## Timing
- Accept edge is cycle 0. CMP occupies cycle 1. `resp_valid` is high from cycle 2.
- Latency from accept to `resp_valid` is 2 cycles.
- Minimum issue interval is 3 cycles, reached when `resp_ready` is already high on entering RESP.
- `req_ready` is a combinational function of state, `ptr` and `req_valid`. It has no path from `resp_ready`.
- All `resp_*` outputs are registered.

## Structure
- Package `slt_arb_pkg` holds:
  - The state enum `arb_state_t` {IDLE, CMP, RESP}.
  - A `next_grant` function: inputs are `req_valid` and `ptr`; outputs are the index and a found flag.
- One sub-module, `slt_core` (parameter `N`):
  - Purely combinational: `a` and `b` in, `lt` and `over` out.
  - Built on the existing `adder_n` with `c_in` = 1 and `b` inverted.
- The arbiter owns all registers.

## Test plan
- Single request, from reset: `req_valid` = 4'b0001, `a` = 5, `b` = 3, `resp_ready` held 1. Expect `req_ready` = 0001 in cycle 0, then `resp_valid` in cycle 2 with `resp_id` = 0, `lt` = 0, `over` = 0.
- Signed and overflow cases, requester 1:
  - `a` = 0x80000000, `b` = 1 gives `lt` = 1, `over` = 1.
  - `a` = 0x7FFFFFFF, `b` = 0xFFFFFFFF gives `lt` = 0, `over` = 1.
  - `a` = `b` = 0xFFFFFFF0 gives `lt` = 0, `over` = 0.
- Round-robin fairness: all four `req_valid` held high continuously. Expect grant order 0, 1, 2, 3, 0, with exactly one `req_ready` bit per grant and a 3-cycle spacing between grants.
- Backpressure: `resp_ready` = 0 for 5 cycles in RESP. Expect `resp_*` stable, `req_ready` all 0, and no new grant until one cycle after `resp_ready` rises.
- Reset mid-operation: assert `rst_n` = 0 in CMP, asynchronously with respect to `clk`. Expect all outputs 0 immediately. After release, the next grant starts from `ptr` = 0 and no stale response appears.
